truth_table_checker: RTL
========================

Name: truth_table_checker

Overview:
- Response-side counterpart to our exhaustive 3-input gate stimulus sweeps.
- Accepts (x,y,z) vectors together with the outputs of two DUT instances (positional- and named-connected) over a valid/ready handshake.
- Compares both outputs against a parameterised 8-entry truth table, and accumulates pass/fail counts, coverage and first-failure info.
- Sits between the stimulus driver and the bench's reporting; signals done once all 8 combinations are checked.

Parameters:
EXPECTED  8'h01  expected output per vector; bit i = expected s/t for {x,y,z}==i (default: 3-input NOR)
CNT_W  8  width of pass/fail counters
STOP_ON_FAIL  0  1 = terminate the run on the first failing vector

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a new run (clears all results)
in_valid  in  1  vector/response beat valid
in_ready  out  1  checker can accept a beat
in_xyz  in  3  applied vector {x,y,z}
in_s  in  1  response of DUT instance 1
in_t  in  1  response of DUT instance 2
busy  out  1  run in progress
done  out  1  run finished
result_ok  out  1  valid when done: all 8 covered and zero fails
pass_cnt  out  CNT_W  passing beats
fail_cnt  out  CNT_W  failing beats
cov_mask  out  8  bit i set once vector i has been checked
first_fail_valid  out  1  a failure has been latched
first_fail_idx  out  3  in_xyz of the first failing beat

Behaviour:
- Reset (async, immediate, including mid-run):
  - state=IDLE, stage register empty.
  - All outputs 0: in_ready, busy, done, result_ok, counters, cov_mask, first_fail_*.
- States IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
- IDLE:
  - in_ready=0; in_valid ignored.
  - start=1 -> RUN next edge; clears counters, cov_mask, first_fail_*, result_ok.
- RUN:
  - Transfer = in_valid && in_ready.
  - On a transfer, in_xyz/in_s/in_t are captured into a one-deep stage register.
  - Compare happens in the following cycle; all result outputs update on the edge after that. Latency transfer->result = 1 cycle. Full throughput: one beat per cycle.
  - exp = EXPECTED[stage_xyz]. Pass iff stage_s==exp AND stage_t==exp; otherwise fail (an s/t disagreement is a fail).
  - Every compared beat sets cov_mask[stage_xyz], whether pass or fail. Repeated vectors count again; the mask is unchanged.
  - pass_cnt/fail_cnt increment by 1 per beat and saturate at 2^CNT_W-1 (no wrap).
  - first_fail_idx/first_fail_valid are latched on the first fail only; later fails leave them unchanged.
  - A staged beat is terminating if (cov_mask | onehot(stage_xyz))==8'hFF, or (STOP_ON_FAIL && it fails).
  - in_ready = RUN && !(stage valid && stage terminating), combinational. At most one beat is in flight at termination; no beat is accepted after it.
  - On the edge that compares a terminating beat: update results, state -> DONE.
  - start asserted in RUN is ignored.
- DONE:
  - in_ready=0. Results held stable.
  - result_ok = (fail_cnt==0 && cov_mask==8'hFF), registered on entry to DONE.
  - start=1 -> clear everything, -> RUN.
- start and in_valid in the same IDLE/DONE cycle: the beat is not accepted (in_ready=0).
- in_valid low in RUN: no update; the stage register empties after its compare.

Test Plan:
1. Correct sweep: start, then vectors 0..7 on consecutive cycles with s=t=EXPECTED[i] -> in_ready falls the cycle after vector 7 is accepted. Next edge: done=1, pass_cnt=8, fail_cnt=0, cov_mask=8'hFF, result_ok=1.
2. Single fault: as (1) but in_t inverted at vector 3 -> pass_cnt=7, fail_cnt=1, first_fail_valid=1, first_fail_idx=3, result_ok=0.
3. STOP_ON_FAIL=1, in_s wrong at vector 2 of sweep 0..7 -> done one cycle after vector 2 accepted, pass_cnt=2, fail_cnt=1, cov_mask=8'h07, no further beats accepted.
4. Repeats and gaps: vectors 0,0,1, idle 3 cycles, then 2..7, all correct -> pass_cnt=9, cov_mask=8'hFF, done asserted only after vector 7.
5. Saturation: CNT_W=2, all-wrong beats vector 0 x6, then 1..7 correct -> fail_cnt=3 (saturated), pass_cnt=3 (saturated), done=1, result_ok=0.
6. Async reset mid-run after 4 beats -> all outputs 0 immediately (before the next edge), state IDLE. A new start plus a clean sweep reproduces scenario 1.

Source files
------------

// File: rtl/truth_table_checker_if.sv
// Beat channel between the stimulus driver and the truth-table checker:
// one applied {x,y,z} vector plus the responses of both DUT instances.
interface truth_table_checker_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_xyz;
    logic       in_s;
    logic       in_t;

    modport master (output in_valid, in_xyz, in_s, in_t, input in_ready);
    modport slave  (input in_valid, in_xyz, in_s, in_t, output in_ready);
endinterface

// File: rtl/truth_table_checker.sv
// Compares DUT responses against an 8-entry truth table and accumulates pass/fail
// counts, vector coverage and first-failure info for one exhaustive 3-input sweep.
module truth_table_checker #(
    parameter logic [7:0] EXPECTED     = 8'h01,
    parameter int         CNT_W        = 8,
    parameter bit         STOP_ON_FAIL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    truth_table_checker_if.slave bus,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 result_ok,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic [7:0]           cov_mask,
    output logic                 first_fail_valid,
    output logic [2:0]           first_fail_idx
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state, state_nxt;
    logic       ready;
    logic       xfer;
    logic       stage_valid;
    logic [2:0] stage_xyz;
    logic       stage_s, stage_t;
    logic       exp_bit;
    logic       stage_fail;
    logic       stage_term;
    logic [7:0] cov_nxt;

    // A staged beat terminates the run once it completes coverage, or on a fail in stop mode.
    assign exp_bit    = EXPECTED[stage_xyz];
    assign stage_fail = (stage_s != exp_bit) || (stage_t != exp_bit);
    assign cov_nxt    = cov_mask | (8'b1 << stage_xyz);
    assign stage_term = stage_valid && ((cov_nxt == 8'hFF) || (STOP_ON_FAIL && stage_fail));
    assign xfer       = bus.in_valid && ready;

    assign bus.in_ready = ready;
    assign busy         = (state == RUN);
    assign done         = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                ready = !stage_term;
                if (stage_term) state_nxt = DONE;
            end
            DONE: if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid      <= 1'b0;
            stage_xyz        <= 3'd0;
            stage_s          <= 1'b0;
            stage_t          <= 1'b0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            cov_mask         <= 8'h00;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= 3'd0;
            result_ok        <= 1'b0;
        end else if (state != RUN) begin
            if (start) begin
                stage_valid      <= 1'b0;
                pass_cnt         <= '0;
                fail_cnt         <= '0;
                cov_mask         <= 8'h00;
                first_fail_valid <= 1'b0;
                first_fail_idx   <= 3'd0;
                result_ok        <= 1'b0;
            end
        end else begin
            stage_valid <= xfer;
            if (xfer) begin
                stage_xyz <= bus.in_xyz;
                stage_s   <= bus.in_s;
                stage_t   <= bus.in_t;
            end
            if (stage_valid) begin
                cov_mask <= cov_nxt;
                if (stage_fail) begin
                    if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
                    if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_idx   <= stage_xyz;
                    end
                end else if (pass_cnt != CNT_MAX) begin
                    pass_cnt <= pass_cnt + 1'b1;
                end
                // Verdict is taken from the post-update counts of the terminating beat.
                if (stage_term)
                    result_ok <= (fail_cnt == '0) && !stage_fail && (cov_nxt == 8'hFF);
            end
        end
    end
endmodule
